pe_operand_feeder: RTL and testbench

//  Transmit side of the PE accumulation protocol (start/valid_in/last/a/b) consumed by pe_no_fifo.

---
 rtl/mm_pkg.sv | 18 +
 rtl/operand_bank.sv | 25 ++
 rtl/pe_operand_feeder.sv | 124 ++++++++++++
 tb/tb_pe_operand_feeder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared defaults and FSM encoding for the PE operand feeder slice.
package mm_pkg;

    localparam int DW_DEF = 4;
    localparam int K_DEF  = 16;
    localparam int M_DEF  = 4;
    localparam int N_DEF  = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } feed_state_e;

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/operand_bank.sv
// Operand register file: one synchronous write port, one combinational read port.
module operand_bank #(
    parameter int DW    = 4,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Contents deliberately survive reset; addresses past the bank are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH))
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/pe_operand_feeder.sv
// Streams A[row][k] / B[k][col] for k=0..K-1 to one PE using start/valid_in/last framing.
module pe_operand_feeder import mm_pkg::*; #(
    parameter  int DATA_WIDTH = DW_DEF,
    parameter  int K          = K_DEF,
    parameter  int M          = M_DEF,
    parameter  int N          = N_DEF,
    localparam int AW         = $clog2(max2(M * K, K * N)),
    localparam int RW         = (M > 1) ? $clog2(M) : 1,
    localparam int CW         = (N > 1) ? $clog2(N) : 1,
    localparam int KW         = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [RW-1:0]         cmd_row,
    input  logic [CW-1:0]         cmd_col,
    input  logic                  stall,
    output logic                  start,
    output logic                  valid_in,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done
);

    feed_state_e           state;
    logic [RW-1:0]         row_q;
    logic [CW-1:0]         col_q;
    logic [KW-1:0]         k_q;
    logic [AW-1:0]         a_raddr, b_raddr;
    logic [DATA_WIDTH-1:0] a_rd, b_rd;
    logic                  row_ok, col_ok, k_last;

    always_comb begin
        row_ok  = 32'(row_q) < M;
        col_ok  = 32'(col_q) < N;
        k_last  = 32'(k_q) == (K - 1);
        a_raddr = AW'(32'(row_q) * K + 32'(k_q));
        b_raddr = AW'(32'(k_q) * N + 32'(col_q));
    end

    operand_bank #(.DW(DATA_WIDTH), .DEPTH(M * K), .AW(AW)) u_bank_a (
        .clk     (clk),
        .wr_en   (wr_en & ~wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (a_raddr),
        .rd_data (a_rd)
    );

    operand_bank #(.DW(DATA_WIDTH), .DEPTH(K * N), .AW(AW)) u_bank_b (
        .clk     (clk),
        .wr_en   (wr_en & wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (b_raddr),
        .rd_data (b_rd)
    );

    assign cmd_ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            start    <= 1'b0;
            valid_in <= 1'b0;
            last     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            a        <= '0;
            b        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    start    <= 1'b0;
                    valid_in <= 1'b0;
                    last     <= 1'b0;
                    done     <= 1'b0;
                    if (cmd_valid) begin
                        row_q <= cmd_row;
                        col_q <= cmd_col;
                        k_q   <= '0;
                        busy  <= 1'b1;
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (stall) begin
                        // Bubble: a/b and k hold so the PE sees a stable operand pair.
                        start    <= 1'b0;
                        valid_in <= 1'b0;
                        last     <= 1'b0;
                        done     <= 1'b0;
                    end else begin
                        a        <= row_ok ? a_rd : '0;
                        b        <= col_ok ? b_rd : '0;
                        valid_in <= 1'b1;
                        start    <= (k_q == '0);
                        last     <= k_last;
                        done     <= k_last;
                        if (k_last) begin
                            k_q   <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Bench for pe_operand_feeder: behavioural model plus directed and random streams on M=4 and M=3 copies.
module tb_pe_operand_feeder;

    localparam int DW = 4;
    localparam int K  = 16;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic clr_n = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en = 0, wr_sel = 0, cmd_valid = 0, stall = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [1:0]    cmd_row = '0, cmd_col = '0;

    logic [1:0]         start_o, valid_o, last_o, done_o, busy_o, rdy_o;
    logic [1:0][DW-1:0] a_o, b_o;

    pe_operand_feeder #(.DATA_WIDTH(DW), .K(K), .M(4), .N(4)) u0 (
        .clk(clk), .clr_n(clr_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .cmd_valid(cmd_valid), .cmd_ready(rdy_o[0]), .cmd_row(cmd_row),
        .cmd_col(cmd_col), .stall(stall), .start(start_o[0]), .valid_in(valid_o[0]),
        .last(last_o[0]), .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    pe_operand_feeder #(.DATA_WIDTH(DW), .K(K), .M(3), .N(4)) u1 (
        .clk(clk), .clr_n(clr_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .cmd_valid(cmd_valid), .cmd_ready(rdy_o[1]), .cmd_row(cmd_row),
        .cmd_col(cmd_col), .stall(stall), .start(start_o[1]), .valid_in(valid_o[1]),
        .last(last_o[1]), .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s u%0d act=%0h want=%0h t=%0t", nm, u, act, want, $time);
        end
    endtask

    // Reference model: banks as arrays, stream as (active,row,col,beat).
    logic [DW-1:0] ma [2][64];
    logic [DW-1:0] mb [2][64];
    logic          m_act [2];
    int            m_row [2], m_col [2], m_k [2];
    logic          e_start [2], e_valid [2], e_last [2], e_done [2];
    logic [DW-1:0] e_a [2], e_b [2];

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int u = 0; u < 2; u++) begin
                m_act[u] <= 0; m_k[u] <= 0; m_row[u] <= 0; m_col[u] <= 0;
                e_start[u] <= 0; e_valid[u] <= 0; e_last[u] <= 0; e_done[u] <= 0;
                e_a[u] <= '0; e_b[u] <= '0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (wr_en) begin
                    if (!wr_sel && (int'(wr_addr) < ((u == 0) ? 64 : 48))) ma[u][wr_addr] <= wr_data;
                    if (wr_sel) mb[u][wr_addr] <= wr_data;
                end
                if (!m_act[u]) begin
                    e_start[u] <= 0; e_valid[u] <= 0; e_last[u] <= 0; e_done[u] <= 0;
                    if (cmd_valid) begin
                        m_act[u] <= 1; m_row[u] <= int'(cmd_row); m_col[u] <= int'(cmd_col); m_k[u] <= 0;
                    end
                end else if (stall) begin
                    e_start[u] <= 0; e_valid[u] <= 0; e_last[u] <= 0; e_done[u] <= 0;
                end else begin
                    e_a[u]     <= (m_row[u] < ((u == 0) ? 4 : 3)) ? ma[u][m_row[u] * K + m_k[u]] : '0;
                    e_b[u]     <= (m_col[u] < 4) ? mb[u][m_k[u] * 4 + m_col[u]] : '0;
                    e_valid[u] <= 1;
                    e_start[u] <= (m_k[u] == 0);
                    e_last[u]  <= (m_k[u] == K - 1);
                    e_done[u]  <= (m_k[u] == K - 1);
                    m_k[u]     <= m_k[u] + 1;
                    if (m_k[u] == K - 1) m_act[u] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                chk("start", u, start_o[u], e_start[u]);
                chk("valid_in", u, valid_o[u], e_valid[u]);
                chk("last", u, last_o[u], e_last[u]);
                chk("done", u, done_o[u], e_done[u]);
                chk("a", u, a_o[u], e_a[u]);
                chk("b", u, b_o[u], e_b[u]);
                chk("busy", u, busy_o[u], m_act[u]);
                chk("cmd_ready", u, rdy_o[u], !m_act[u]);
            end
        end
    end

    int r_beats, r_sum, r_asum, r_bones, r_starts, r_start_bad, r_lasts, r_dones;
    int r_last_beat, r_first_t, r_last_t, r_hold_bad;
    logic [DW-1:0] r_a [16];

    task automatic wr(input logic sel, input int addr, input int data);
        wr_en = 1; wr_sel = sel; wr_addr = AW'(addr); wr_data = DW'(data);
        @(negedge clk);
        wr_en = 0;
    endtask

    // Issue one command and record the stream seen on instance ob; ab>=0 stops after that beat.
    task automatic run_cmd(input int rr, input int cc, input bit stog, input int wb,
                           input int ob, input int ab);
        bit seen;
        logic [DW-1:0] pa, pb;
        pa = '0; pb = '0; seen = 0;
        cmd_valid = 1; cmd_row = 2'(rr); cmd_col = 2'(cc); stall = 0;
        @(negedge clk);
        cmd_valid = 0;
        r_beats = 0; r_sum = 0; r_asum = 0; r_bones = 0; r_starts = 0; r_start_bad = 0;
        r_lasts = 0; r_dones = 0; r_last_beat = -1; r_first_t = -1; r_last_t = -1; r_hold_bad = 0;
        for (int t = 0; t < 60 && !seen; t++) begin
            stall = stog && (t % 2 == 1);
            if (wb >= 0 && t == wb) begin
                wr_en = 1; wr_sel = 0; wr_addr = AW'(26); wr_data = '0;
            end else begin
                wr_en = 0;
            end
            @(negedge clk);
            if (valid_o[ob]) begin
                if (r_beats < 16) r_a[r_beats] = a_o[ob];
                if (r_beats == 0) r_first_t = t;
                r_sum  += int'(a_o[ob]) * int'(b_o[ob]);
                r_asum += int'(a_o[ob]);
                if (b_o[ob] == 1) r_bones++;
                if (start_o[ob]) begin r_starts++; if (r_beats != 0) r_start_bad++; end
                if (done_o[ob]) r_dones++;
                if (last_o[ob]) begin r_lasts++; r_last_beat = r_beats; r_last_t = t; seen = 1; end
                pa = a_o[ob]; pb = b_o[ob];
                r_beats++;
                if (ab >= 0 && r_beats == ab + 1) seen = 1;
            end else if (r_beats > 0) begin
                if (a_o[ob] !== pa || b_o[ob] !== pb || start_o[ob] || last_o[ob] || done_o[ob])
                    r_hold_bad++;
            end
        end
        stall = 0; wr_en = 0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL stream_timeout u%0d act=no_last want=last_within_60", ob);
        end
    endtask

    task automatic chk_test1(input string tag);
        int seq_bad;
        seq_bad = 0;
        for (int k = 0; k < 16; k++) if (r_a[k] !== DW'(k)) seq_bad++;
        chk({tag, "_beats"}, 0, r_beats, 16);
        chk({tag, "_pe_c"}, 0, r_sum, 120);
        chk({tag, "_aseq_bad"}, 0, seq_bad, 0);
        chk({tag, "_b_ones"}, 0, r_bones, 16);
        chk({tag, "_starts"}, 0, r_starts, 1);
        chk({tag, "_start_pos"}, 0, r_start_bad, 0);
        chk({tag, "_last_beat"}, 0, r_last_beat, 15);
        chk({tag, "_dones"}, 0, r_dones, 1);
    endtask

    initial begin
        #1 clr_n = 0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_start", u, start_o[u], 0);
            chk("rst_valid", u, valid_o[u], 0);
            chk("rst_last", u, last_o[u], 0);
            chk("rst_busy", u, busy_o[u], 0);
            chk("rst_a", u, a_o[u], 0);
            chk("rst_ready", u, rdy_o[u], 1);
        end
        clr_n = 1;
        chk_en = 1;

        for (int i = 0; i < 64; i++) begin
            wr(0, i, $urandom_range(15));
            wr(1, i, $urandom_range(15));
        end
        for (int k = 0; k < 16; k++) begin
            wr(0, 16 + k, k);
            wr(1, k * 4 + 2, 1);
        end

        run_cmd(1, 2, 0, -1, 0, -1);
        chk_test1("t1");

        run_cmd(1, 2, 1, -1, 0, -1);
        chk("t2_beats", 0, r_beats, 16);
        chk("t2_span", 0, r_last_t - r_first_t + 1, 31);
        chk("t2_hold_bad", 0, r_hold_bad, 0);
        chk("t2_starts", 0, r_starts, 1);
        chk("t2_lasts", 0, r_lasts, 1);

        run_cmd(1, 2, 0, 5, 0, -1);
        chk("t5_early_wr", 0, r_a[10], 0);
        wr(0, 26, 10);
        run_cmd(1, 2, 0, 10, 0, -1);
        chk("t5_same_edge_wr", 0, r_a[10], 10);
        wr(0, 26, 10);

        run_cmd(1, 2, 0, -1, 0, 7);
        chk("t4_beats_before_rst", 0, r_beats, 8);
        #1 clr_n = 0;
        @(negedge clk);
        chk("t4_start", 0, start_o[0], 0);
        chk("t4_valid", 0, valid_o[0], 0);
        chk("t4_last", 0, last_o[0], 0);
        chk("t4_done", 0, done_o[0], 0);
        chk("t4_ab", 0, {a_o[0], b_o[0]}, 0);
        chk("t4_busy", 0, busy_o[0], 0);
        clr_n = 1;
        @(negedge clk);
        chk("t4_ready_after", 0, rdy_o[0], 1);
        run_cmd(1, 2, 0, -1, 0, -1);
        chk_test1("t4");

        for (int i = 48; i < 64; i++) wr(0, i, 9);
        run_cmd(3, 2, 0, -1, 1, -1);
        chk("t6_beats", 1, r_beats, 16);
        chk("t6_asum", 1, r_asum, 0);
        chk("t6_b_ones", 1, r_bones, 16);
        chk("t6_last_beat", 1, r_last_beat, 15);
        chk("t6_dones", 1, r_dones, 1);

        for (int i = 0; i < 64; i++) begin
            wr(0, i, 15);
            wr(1, i, 15);
        end
        begin
            int l1, s2, nbeats, rdy_bad;
            bit fin;
            l1 = -1; s2 = -1; nbeats = 0; rdy_bad = 0; fin = 0;
            cmd_valid = 1; cmd_row = 0; cmd_col = 0;
            @(negedge clk);
            cmd_row = 3; cmd_col = 3;
            for (int t = 0; t < 80 && !fin; t++) begin
                @(negedge clk);
                if (l1 >= 0 && t == l1 + 1) cmd_valid = 0;
                if (valid_o[0]) begin
                    nbeats++;
                    if (!last_o[0] && rdy_o[0]) rdy_bad++;
                    if (a_o[0] != 15 || b_o[0] != 15) rdy_bad++;
                    if (start_o[0] && l1 >= 0 && s2 < 0) s2 = t;
                    if (last_o[0]) begin
                        if (l1 < 0) l1 = t;
                        else fin = 1;
                    end
                end
            end
            cmd_valid = 0;
            chk("t3_finished", 0, fin, 1);
            chk("t3_gap", 0, s2 - l1, 2);
            chk("t3_beats", 0, nbeats, 32);
            chk("t3_ready_or_data_bad", 0, rdy_bad, 0);
        end

        for (int c = 0; c < 400; c++) begin
            wr_en     = ($urandom_range(2) == 0);
            wr_sel    = 1'($urandom_range(1));
            wr_addr   = AW'($urandom_range(63));
            wr_data   = DW'($urandom_range(15));
            cmd_valid = ($urandom_range(2) == 0);
            cmd_row   = 2'($urandom_range(3));
            cmd_col   = 2'($urandom_range(3));
            stall     = ($urandom_range(3) == 0);
            @(negedge clk);
        end
        wr_en = 0; cmd_valid = 0; stall = 0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
